// File: rtl/core_pkg.sv
// Shared types and encodings for the RV32I core's pipeline hazard logic.
// Shadow entries carry destination-register metadata for the E/M/W stages.
package core_pkg;

    localparam int RD_W = 5;

    localparam logic [1:0] WB_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            is_load;
    } shadow_entry_t;

    // A stage can only source a hazard if it will actually write a non-x0 register.
    function automatic logic entry_hit(
        input shadow_entry_t   ent,
        input logic [RD_W-1:0] rs,
        input logic            use_rs
    );
        return ent.valid && ent.we && (ent.rd != '0) && (ent.rd == rs) && use_rs;
    endfunction

    // Youngest producer wins; a load in E cannot supply its data yet.
    function automatic logic [1:0] fwd_select(
        input shadow_entry_t   e_ent,
        input shadow_entry_t   m_ent,
        input logic [RD_W-1:0] rs,
        input logic            use_rs
    );
        if (entry_hit(e_ent, rs, use_rs) && !e_ent.is_load) begin
            return FWD_M;
        end else if (entry_hit(m_ent, rs, use_rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/shadow_stage.sv
// One shadow pipeline register: hold has priority over bubble, bubble over load.
module shadow_stage
    import core_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          bubble,
    input  shadow_entry_t d,
    output shadow_entry_t q
);

    shadow_entry_t entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_reg <= '0;
        end else if (hold) begin
            entry_reg <= entry_reg;
        end else if (bubble) begin
            entry_reg <= '0;
        end else begin
            entry_reg <= d;
        end
    end

    assign q = entry_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall/flush decode from a private
// shadow of E/M/W destination metadata, plus registered E-stage forward selects.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic              use_rs1_D,
    input  logic              use_rs2_D,
    input  logic [REG_AW-1:0] rd_D,
    input  logic              we_reg_D,
    input  logic [1:0]        wb_ctrl_D,
    input  logic              valid_D,
    input  logic              redirect_E,
    input  logic              mem_busy_M,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              stall_M,
    output logic              stall_W,
    output logic              flush_D,
    output logic              flush_E,
    output logic [1:0]        fwd_a_E,
    output logic [1:0]        fwd_b_E
);

    localparam int NUM_STAGES = 3;

    shadow_entry_t   shadow_in [NUM_STAGES];
    shadow_entry_t   shadow_q  [NUM_STAGES];
    shadow_entry_t   entry_d;
    logic [RD_W-1:0] rs1_w;
    logic [RD_W-1:0] rs2_w;

    logic freeze;
    logic redirect_act;
    logic load_use;
    logic bubble_e;

    logic [1:0] fwd_a_reg;
    logic [1:0] fwd_b_reg;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    assign rs1_w = RD_W'(rs1_D);
    assign rs2_w = RD_W'(rs2_D);

    always_comb begin
        entry_d         = '0;
        entry_d.valid   = valid_D;
        entry_d.rd      = RD_W'(rd_D);
        entry_d.we      = we_reg_D;
        entry_d.is_load = (wb_ctrl_D == WB_LOAD);
    end

    // Priority: freeze, then redirect, then load-use; redirect squashes load-use.
    assign freeze       = mem_busy_M;
    assign redirect_act = !freeze && redirect_E;
    assign load_use     = !freeze && !redirect_E && valid_D && shadow_q[0].is_load &&
                          (entry_hit(shadow_q[0], rs1_w, use_rs1_D) ||
                           entry_hit(shadow_q[0], rs2_w, use_rs2_D));
    assign bubble_e     = redirect_act || load_use;

    assign stall_F = freeze || load_use;
    assign stall_D = freeze || load_use;
    assign stall_E = freeze;
    assign stall_M = freeze;
    assign stall_W = freeze;
    assign flush_D = redirect_act;
    assign flush_E = bubble_e;

    // Stage 0 = E (fed from D), 1 = M, 2 = W; only E ever takes a bubble.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_shadow
            if (gi == 0) begin : g_head
                assign shadow_in[gi] = entry_d;
            end else begin : g_tail
                assign shadow_in[gi] = shadow_q[gi-1];
            end

            shadow_stage u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .hold   (freeze),
                .bubble ((gi == 0) ? bubble_e : 1'b0),
                .d      (shadow_in[gi]),
                .q      (shadow_q[gi])
            );
        end
    endgenerate

    // W needs no forward from D: the register file writes before it reads.
    assign fwd_a_next = fwd_select(shadow_q[0], shadow_q[1], rs1_w, use_rs1_D);
    assign fwd_b_next = fwd_select(shadow_q[0], shadow_q[1], rs2_w, use_rs2_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end else if (freeze) begin
            fwd_a_reg <= fwd_a_reg;
            fwd_b_reg <= fwd_b_reg;
        end else if (bubble_e) begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end else begin
            fwd_a_reg <= fwd_a_next;
            fwd_b_reg <= fwd_b_next;
        end
    end

    assign fwd_a_E = fwd_a_reg;
    assign fwd_b_E = fwd_b_reg;

endmodule
